// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and the divide-by-zero quotient value.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int          CALC_CYCLES = 32;
    localparam logic [4:0]  CNT_LAST    = 5'(CALC_CYCLES - 1);
    localparam logic [31:0] DIVZERO_LO  = 32'hFFFF_FFFF;

    // Low encoding bit clear means the operands are two's complement.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negation. Used to take operand magnitudes when
// an operation is latched and to restore result signs in the fix-up cycle.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    // Negate when requested; negating the most negative value wraps to itself.
    always_comb begin
        val_o = neg_i ? (~val_i + W'(1)) : val_i;
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle (shift-add multiply, restoring divide) on operand
// magnitudes, followed by a single sign-fix cycle. Latency is fixed at 34
// cycles from start to done for every operation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; mthi/mtlo accepted when start is low
// ST_CALC | 32 iterations on the working register
// ST_FIX  | sign correction, HI/LO write, done pulse follows
module mdu
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              div_q;
    logic              neg_q;
    logic              rneg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q;

    op_e               op_in;
    logic              sgn_in;
    logic              accept;
    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign op_in  = op_e'(op);
    assign sgn_in = op_is_signed(op_in);
    assign accept = (state_q == ST_IDLE) && start;

    mdu_signfix #(.W(XLEN)) u_rs_mag (
        .val_i (rs),
        .neg_i (sgn_in & rs[XLEN-1]),
        .val_o (rs_mag)
    );

    mdu_signfix #(.W(XLEN)) u_rt_mag (
        .val_i (rt),
        .neg_i (sgn_in & rt[XLEN-1]),
        .val_o (rt_mag)
    );

    mdu_signfix #(.W(2*XLEN)) u_prod_fix (
        .val_i (acc_q),
        .neg_i (neg_q),
        .val_o (prod_fix)
    );

    mdu_signfix #(.W(XLEN)) u_quo_fix (
        .val_i (acc_q[XLEN-1:0]),
        .neg_i (neg_q),
        .val_o (quo_fix)
    );

    mdu_signfix #(.W(XLEN)) u_rem_fix (
        .val_i (acc_q[2*XLEN-1:XLEN]),
        .neg_i (rneg_q),
        .val_o (rem_fix)
    );

    // State and iteration counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> CALC on start, 32 CALC cycles, one FIX cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One iteration. Multiply keeps {partial_hi, multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left. A zero
    // divisor always "fits", leaving quotient all ones and remainder = dividend.
    always_comb begin
        logic [XLEN:0] mult_sum;
        logic [XLEN:0] div_top;
        logic [XLEN:0] div_diff;
        logic          div_ge;
        mult_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
        if (acc_q[0]) begin
            mult_sum = mult_sum + {1'b0, opnd_q};
        end
        div_top  = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_top - {1'b0, opnd_q};
        div_ge   = ~div_diff[XLEN];
        if (div_q) begin
            step_acc = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge};
        end else begin
            step_acc = {mult_sum, acc_q[XLEN-1:1]};
        end
    end

    // Working register, operand register and sign flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            div_q  <= op_is_div(op_in);
            neg_q  <= sgn_in & (rs[XLEN-1] ^ rt[XLEN-1]);
            rneg_q <= sgn_in & rs[XLEN-1];
            if (op_is_div(op_in)) begin
                opnd_q <= rt_mag;
                acc_q  <= {{XLEN{1'b0}}, rs_mag};
            end else begin
                opnd_q <= rs_mag;
                acc_q  <= {{XLEN{1'b0}}, rt_mag};
            end
        end else if (state_q == ST_CALC) begin
            acc_q <= step_acc;
        end
    end

    // HI/LO: written by FIX or by an idle move; done follows FIX by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FIX);
            if (state_q == ST_FIX) begin
                if (div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= (opnd_q == '0) ? DIVZERO_LO : quo_fix;
                end else begin
                    hi_q <= prod_fix[2*XLEN-1:XLEN];
                    lo_q <= prod_fix[XLEN-1:0];
                end
            end else if ((state_q == ST_IDLE) && !start) begin
                if (mthi) hi_q <= wdata;
                if (mtlo) lo_q <= wdata;
            end
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed testbench for mdu: timing, arithmetic corners, moves and reset.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs, rt, wdata;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mdu #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive a start for one cycle beginning at the next falling edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
    endtask

    // Count cycles after the start cycle until done (-1 if never), and note
    // whether busy ever departed from high-for-33-cycles.
    task automatic wait_done(output int lat, output bit busy_bad);
        lat      = -1;
        busy_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (busy !== ((k <= 33) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat;
        bit bb;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        // First start on the first edge with reset released.
        rst_n = 1'b1;
        start = 1'b1; op = 2'b00; rs = 32'hFFFF_FFFE; rt = 32'h0000_0003;
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency: got %0d expected 34", lat); end
        checks++; if (bb !== 1'b0) begin errors++; $display("FAIL mult_busy_window: got bad=%b expected 0", bb); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFFA); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_multu;
        int lat;
        bit bb;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", hi, 32'hFFFF_FFFE); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected %h", lo, 32'h0000_0001); end
    endtask

    task automatic test_divide;
        int lat;
        bit bb;
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d expected 34", lat); end
        checks++; if (bb !== 1'b0) begin errors++; $display("FAIL div_busy_window: got bad=%b expected 0", bb); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        issue(2'b11, 32'h0000_0007, 32'h0000_0002);
        wait_done(lat, bb);
        checks++; if (lo !== 32'h0000_0003) begin errors++; $display("FAIL divu_lo: got %h expected %h", lo, 32'h3); end
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL divu_hi: got %h expected %h", hi, 32'h1); end
        // Positive dividend, negative divisor: 100 / -7 = -14 rem 2.
        issue(2'b10, 32'h0000_0064, 32'hFFFF_FFF9);
        wait_done(lat, bb);
        checks++; if (lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_negdiv_lo: got %h expected %h", lo, 32'hFFFF_FFF2); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL div_negdiv_hi: got %h expected %h", hi, 32'h2); end
    endtask

    task automatic test_div_corner;
        int lat;
        bit bb;
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bb);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'h0000_0000) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
        issue(2'b11, 32'h0000_0005, 32'h0000_0000);
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 34", lat); end
        checks++; if (hi !== 32'h0000_0005) begin errors++; $display("FAIL divu_zero_hi: got %h expected %h", hi, 32'h5); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
        issue(2'b10, 32'hFFFF_FFFB, 32'h0000_0000);
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_zero_latency: got %0d expected 34", lat); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div_zero_hi: got %h expected %h", hi, 32'hFFFF_FFFB); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit bb;
        int dones   = 0;
        int done_at = -1;
        issue(2'b11, 32'd100, 32'd7);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            start = 1'b0;
            mtlo  = 1'b0;
            if (k == 5) begin
                start = 1'b1; op = 2'b00; rs = 32'd3; rt = 32'd4;
            end
            if (k == 7) begin
                op = 2'b01; rs = 32'h1234_5678; rt = 32'h0000_0000;
            end
            if (k == 10) begin
                mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", dones); end
        checks++; if (done_at !== 34) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 34", done_at); end
        checks++; if (lo !== 32'h0000_000E) begin errors++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'hE); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL b2b_hi: got %h expected %h", hi, 32'h2); end
        // Start in the done cycle is accepted.
        start = 1'b1; op = 2'b00; rs = 32'hFFFF_FFFD; rt = 32'h0000_0004;
        wait_done(lat, bb);
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFF4) begin errors++; $display("FAIL b2b_second_lo: got %h expected %h", lo, 32'hFFFF_FFF4); end
    endtask

    task automatic test_reset_mid_op;
        int  dones = 0;
        bit  busy_seen = 1'b0;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo: got %h expected %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: got %b expected 0", busy_seen); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrst_no_write: got %h expected %h", lo, 32'h0); end
    endtask

    task automatic test_moves;
        int lat;
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected %h", hi, 32'h1234_5678); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, 32'h0); end
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'hAAAA_5555) begin errors++; $display("FAIL both_hi: got %h expected %h", hi, 32'hAAAA_5555); end
        checks++; if (lo !== 32'hAAAA_5555) begin errors++; $display("FAIL both_lo: got %h expected %h", lo, 32'hAAAA_5555); end
        // Move in the same cycle as an accepted start, and a move while busy.
        start = 1'b1; op = 2'b01; rs = 32'd2; rt = 32'd3;
        mtlo = 1'b1; wdata = 32'h7777_7777;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
            if (k == 1) begin
                checks++; if (lo !== 32'hAAAA_5555) begin errors++; $display("FAIL start_mtlo_ignored: got %h expected %h", lo, 32'hAAAA_5555); end
            end
            if (k == 5) begin
                mthi = 1'b1; wdata = 32'h0BAD_F00D;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        mthi = 1'b0;
        checks++; if (lat !== 34) begin errors++; $display("FAIL moves_latency: got %0d expected 34", lat); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL busy_mthi_ignored: got %h expected %h", hi, 32'h0); end
        checks++; if (lo !== 32'h6) begin errors++; $display("FAIL moves_lo: got %h expected %h", lo, 32'h6); end
        // With nothing requested, HI/LO hold.
        repeat (3) @(negedge clk);
        checks++; if (lo !== 32'h6) begin errors++; $display("FAIL hold_lo: got %h expected %h", lo, 32'h6); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divide();
        test_div_corner();
        test_back_to_back();
        test_reset_mid_op();
        test_moves();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
